// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mcu_pkg
//  Description : Shared encodings for the multi-cycle MIPS control unit:
//                state codes, opcodes and datapath select encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] LOAD_WORD   = 2'b00;
  localparam logic [1:0] LOAD_HALF_S = 2'b01;
  localparam logic [1:0] LOAD_HALF_U = 2'b10;

  // Load width/extension selected by the load opcode; anything else is a word
  function automatic logic [1:0] load_kind_of(input logic [5:0] op);
    if (op == OP_LH)       return LOAD_HALF_S;
    else if (op == OP_LHU) return LOAD_HALF_U;
    else                   return LOAD_WORD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_wait_timer
//  Description : Counts consecutive memReady-low cycles while a memory access
//                state is active and flags the cycle at which the limit is hit.
//  Revision    : 1.0  initial release
// ============================================================================
module mcu_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic limit_hit
);

  localparam logic [7:0] C_LAST = 8'(WAIT_MAX - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // A ready in the limit cycle is a completion, so the compare needs ready low
  assign limit_hit = active & ~mem_ready & (cnt_q == C_LAST);

  // Count stalled cycles; clear on completion, timeout or leaving the state
  always_comb begin
    cnt_d = 8'd0;
    if (active && !mem_ready && !limit_hit) cnt_d = cnt_q + 8'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Multi-cycle control FSM for a MIPS subset (R-type, ADDI,
//                ANDI, ORI, LW, LH, LHU, SW, BEQ). Sequences fetch, decode,
//                execute, memory and writeback; stalls on memReady and traps
//                on illegal opcodes or memory timeout.
//                Optional: define MCU_JUMP_EN to execute J (opcode 0x02).
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int WAIT_MAX = 15,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                memToReg,
  output logic                regDst,
  output logic                regWrite,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic [1:0]          pcSource,
  output logic [1:0]          loadKind,
  output logic                illegalOp,
  output logic                memTimeout,
  output logic [STATE_W-1:0]  state
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;

  logic timer_active;
  logic limit_hit;
  logic pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  assign timer_active = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mcu_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (timer_active),
    .mem_ready (memReady),
    .limit_hit (limit_hit)
  );

  // Next-state, opcode latch and sticky fault flags
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH: begin
        if (memReady) state_d = S_DECODE;
        else if (limit_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OPCODE_W'(OP_RTYPE): state_d = S_REX;
          OPCODE_W'(OP_ADDI),
          OPCODE_W'(OP_ANDI),
          OPCODE_W'(OP_ORI):   state_d = S_IEX;
          OPCODE_W'(OP_LW),
          OPCODE_W'(OP_LH),
          OPCODE_W'(OP_LHU),
          OPCODE_W'(OP_SW):    state_d = S_MEMADR;
          OPCODE_W'(OP_BEQ):   state_d = S_BRANCH;
`ifdef MCU_JUMP_EN
          OPCODE_W'(OP_J):     state_d = S_JUMP;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
      S_MEMRD, S_MEMWR: begin
        if (memReady) state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        else if (limit_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_REX:    state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_IEX:    state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
`ifdef MCU_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      default:  state_d = S_TRAP;
    endcase
  end

  // State, latched opcode and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Control outputs decoded from the current state and latched opcode
  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    iorD              = 1'b0;
    memRead           = 1'b0;
    memToReg          = 1'b0;
    regDst            = 1'b0;
    aluSrcA           = 1'b0;
    aluSrcB           = SRCB_RT;
    aluOp             = ALUOP_ADD;
    pcSource          = PCSRC_ALU;
    loadKind          = LOAD_WORD;
    case (state_q)
      S_FETCH: begin
        memRead      = 1'b1;
        aluSrcB      = SRCB_FOUR;
        ir_write_raw = memReady;
        pc_write_raw = memReady;
      end
      S_DECODE: aluSrcB = SRCB_IMM_SH2;
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        memRead  = 1'b1;
        iorD     = 1'b1;
        loadKind = load_kind_of(6'(op_q));
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        memToReg      = 1'b1;
        loadKind      = load_kind_of(6'(op_q));
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        iorD          = 1'b1;
      end
      S_REX: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write_raw = 1'b1;
        regDst        = 1'b1;
      end
      S_IEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluOp   = (op_q == OPCODE_W'(OP_ADDI)) ? ALUOP_ADD : ALUOP_LOGIC;
      end
      S_IWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        aluSrcA           = 1'b1;
        aluOp             = ALUOP_SUB;
        pc_write_cond_raw = 1'b1;
        pcSource          = PCSRC_ALUOUT;
      end
`ifdef MCU_JUMP_EN
      S_JUMP: begin
        pc_write_raw = 1'b1;
        pcSource     = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

  // Reset abandons any in-flight access, so no write may escape while it is high
  assign pcWrite     = pc_write_raw      & ~reset;
  assign pcWriteCond = pc_write_cond_raw & ~reset;
  assign memWrite    = mem_write_raw     & ~reset;
  assign irWrite     = ir_write_raw      & ~reset;
  assign regWrite    = reg_write_raw     & ~reset;

  assign illegalOp  = illegal_q;
  assign memTimeout = timeout_q;
  assign state      = STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Self-checking bench for multicycle_control_unit: directed
//                scenarios plus a random instruction stream compared against
//                an instruction-level expected-trace model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam int WAIT_MAX = 4;
`ifdef MCU_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       memReady;
  logic [5:0] opcode;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource, loadKind;
  logic       illegalOp, memTimeout;
  logic [3:0] state;

  multicycle_control_unit #(
    .OPCODE_W (6),
    .WAIT_MAX (WAIT_MAX),
    .STATE_W  (4)
  ) dut (
    .clk (clk), .reset (reset), .opcode (opcode), .memReady (memReady),
    .pcWrite (pcWrite), .pcWriteCond (pcWriteCond), .iorD (iorD),
    .memRead (memRead), .memWrite (memWrite), .irWrite (irWrite),
    .memToReg (memToReg), .regDst (regDst), .regWrite (regWrite),
    .aluSrcA (aluSrcA), .aluSrcB (aluSrcB), .aluOp (aluOp),
    .pcSource (pcSource), .loadKind (loadKind), .illegalOp (illegalOp),
    .memTimeout (memTimeout), .state (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource, loadKind;
  } ctrl_t;

  ctrl_t obs;
  assign obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                memToReg, regDst, regWrite, aluSrcA,
                aluSrcB, aluOp, pcSource, loadKind};

  // One expected cycle of an instruction: phase number, memReady, flags, opcode
  typedef struct {
    int       st;
    bit       rdy;
    bit       ill;
    bit       tmo;
    logic [5:0] op;
  } step_t;

  step_t plan[$];

  // Control word each phase must produce, written from the phase descriptions
  function automatic ctrl_t exp_ctrl(int st, logic [5:0] op, bit rdy);
    ctrl_t c = '0;
    logic [1:0] lk = (op == 6'h21) ? 2'd1 : (op == 6'h25) ? 2'd2 : 2'd0;
    case (st)
      0:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
      1:  c.aluSrcB = 2'b11;
      2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      3:  begin c.memRead = 1; c.iorD = 1; c.loadKind = lk; end
      4:  begin c.regWrite = 1; c.memToReg = 1; c.loadKind = lk; end
      5:  begin c.memWrite = 1; c.iorD = 1; end
      6:  begin c.aluSrcA = 1; c.aluOp = 2'b10; end
      7:  begin c.regWrite = 1; c.regDst = 1; end
      8:  begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01; end
      9:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; c.aluOp = (op == 6'h08) ? 2'b00 : 2'b11; end
      10: c.regWrite = 1;
      11: begin c.pcWrite = 1; c.pcSource = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    memReady = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  function automatic void push(int st, bit rdy, bit ill, bit tmo, logic [5:0] op);
    step_t s;
    s.st = st; s.rdy = rdy; s.ill = ill; s.tmo = tmo; s.op = op;
    plan.push_back(s);
  endfunction

  // A memory access taking 'lat' stalled cycles; returns 1 if it times out
  function automatic bit plan_access(int st, int lat, logic [5:0] op);
    if (lat >= WAIT_MAX) begin
      for (int i = 0; i < WAIT_MAX; i++) push(st, 1'b0, 1'b0, 1'b0, op);
      for (int i = 0; i < 3; i++) push(12, 1'($urandom_range(0, 1)), 1'b0, 1'b1, op);
      return 1'b1;
    end
    for (int i = 0; i < lat; i++) push(st, 1'b0, 1'b0, 1'b0, op);
    push(st, 1'b1, 1'b0, 1'b0, op);
    return 1'b0;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    memReady = 1'b1;
    opcode   = 6'($urandom);
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++;
    if (obs !== ctrl_t'({10'b0001000000, 8'b01000000})) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, ctrl_t'({10'b0001000000, 8'b01000000}));
    end
    n_checks++;
    if ({illegalOp, memTimeout} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00", {illegalOp, memTimeout});
    end
    tick();
    reset    = 1'b0;
    memReady = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_ctrl(0, 6'h00, 1'b0)) begin
      n_fail++; $display("FAIL reset_fetch_idle: got %h want %h", obs, exp_ctrl(0, 6'h00, 1'b0));
    end
    tick();
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    do_reset();
    memReady = 1'b1;
    opcode   = 6'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 4'(exp_st[i]) || regWrite !== (i == 3) || regDst !== (i == 3)) begin
        n_fail++;
        $display("FAIL rtype_step%0d: got st=%0d rw=%b rd=%b want st=%0d rw=%b rd=%b",
                 i, state, regWrite, regDst, exp_st[i], (i == 3), (i == 3));
      end
      tick();
    end
  endtask

  task automatic test_load_stall();
    do_reset();
    opcode   = 6'h21;
    memReady = 1'b1;
    tick();
    tick();
    opcode   = 6'($urandom);
    memReady = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 4'd3 || memRead !== 1'b1 || iorD !== 1'b1 || loadKind !== 2'd1) begin
        n_fail++;
        $display("FAIL lh_stall%0d: got st=%0d rd=%b iord=%b lk=%0d want st=3 rd=1 iord=1 lk=1",
                 i, state, memRead, iorD, loadKind);
      end
      tick();
    end
    memReady = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (state !== 4'd4 || loadKind !== 2'd1 || memToReg !== 1'b1 || regWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL lh_writeback: got st=%0d lk=%0d m2r=%b rw=%b want st=4 lk=1 m2r=1 rw=1",
               state, loadKind, memToReg, regWrite);
    end
    tick();
  endtask

  task automatic test_store();
    int exp_st[5] = '{0, 1, 2, 5, 0};
    do_reset();
    memReady = 1'b1;
    opcode   = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 4'(exp_st[i]) || memWrite !== (i == 3) || iorD !== (i == 3) || regWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_step%0d: got st=%0d mw=%b iord=%b rw=%b want st=%0d mw=%b iord=%b rw=0",
                 i, state, memWrite, iorD, regWrite, exp_st[i], (i == 3), (i == 3));
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    memReady = 1'b1;
    opcode   = 6'h3F;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      memReady = 1'($urandom_range(0, 1));
      opcode   = 6'($urandom);
      @(negedge clk);
      n_checks++;
      if (state !== 4'd12 || illegalOp !== 1'b1 || obs !== ctrl_t'(0)) begin
        n_fail++;
        $display("FAIL illegal_trap%0d: got st=%0d ill=%b ctrl=%h want st=12 ill=1 ctrl=0",
                 i, state, illegalOp, obs);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    memReady = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 4'd0 || illegalOp !== 1'b0 || memTimeout !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: got st=%0d ill=%b tmo=%b want st=0 ill=0 tmo=0",
               state, illegalOp, memTimeout);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    memReady = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 4'd0) begin n_fail++; $display("FAIL timeout_wait%0d: got st=%0d want 0", i, state); end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (state !== 4'd12 || memTimeout !== 1'b1 || illegalOp !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_trap: got st=%0d tmo=%b ill=%b want st=12 tmo=1 ill=0",
               state, memTimeout, illegalOp);
    end
    do_reset();
    memReady = 1'b0;
    for (int i = 0; i < WAIT_MAX - 1; i++) tick();
    memReady = 1'b1;
    opcode   = 6'h00;
    tick();
    @(negedge clk);
    n_checks++;
    if (state !== 4'd1 || memTimeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_edge_ready: got st=%0d tmo=%b want st=1 tmo=0", state, memTimeout);
    end
    tick();
  endtask

  task automatic test_jump();
    int   exp_st;
    ctrl_t exp_c;
`ifdef MCU_JUMP_EN
    exp_st = 11;
`else
    exp_st = 12;
`endif
    exp_c = exp_ctrl(exp_st, 6'h02, 1'b1);
    do_reset();
    memReady = 1'b1;
    opcode   = 6'h02;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (state !== 4'(exp_st) || obs !== exp_c || illegalOp !== !JUMP_EN) begin
      n_fail++;
      $display("FAIL jump: got st=%0d ctrl=%h ill=%b want st=%0d ctrl=%h ill=%b",
               state, obs, illegalOp, exp_st, exp_c, !JUMP_EN);
    end
    tick();
  endtask

  task automatic test_midflight_reset();
    do_reset();
    memReady = 1'b1;
    opcode   = 6'h23;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state !== 4'd4 || regWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset: got st=%0d rw=%b want st=4 rw=0", state, regWrite);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL midflight_refetch: got st=%0d want 0", state); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops[12] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h21,
                            6'h25, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h01};
    do_reset();
    for (int k = 0; k < 80; k++) begin
      logic [5:0] op;
      int  lf, lm;
      bit  trapped;
      step_t s;
      op = ops[$urandom_range(0, 11)];
      lf = ($urandom_range(0, 9) == 0) ? WAIT_MAX : int'($urandom_range(0, 2));
      lm = ($urandom_range(0, 9) == 0) ? WAIT_MAX : int'($urandom_range(0, 2));
      plan.delete();
      trapped = plan_access(0, lf, op);
      if (!trapped) begin
        push(1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, op);
        case (op)
          6'h00: begin push(6, 1'b1, 0, 0, op); push(7, 1'b0, 0, 0, op); end
          6'h08, 6'h0C, 6'h0D: begin push(9, 1'b0, 0, 0, op); push(10, 1'b1, 0, 0, op); end
          6'h04: push(8, 1'($urandom_range(0, 1)), 0, 0, op);
          6'h23, 6'h21, 6'h25: begin
            push(2, 1'($urandom_range(0, 1)), 0, 0, op);
            trapped = plan_access(3, lm, op);
            if (!trapped) push(4, 1'($urandom_range(0, 1)), 0, 0, op);
          end
          6'h2B: begin
            push(2, 1'($urandom_range(0, 1)), 0, 0, op);
            trapped = plan_access(5, lm, op);
          end
          default: begin
            if (op == 6'h02 && JUMP_EN) push(11, 1'b0, 0, 0, op);
            else begin
              trapped = 1'b1;
              for (int i = 0; i < 3; i++) push(12, 1'($urandom_range(0, 1)), 1'b1, 1'b0, op);
            end
          end
        endcase
      end
      while (plan.size() > 0) begin
        s        = plan.pop_front();
        memReady = s.rdy;
        opcode   = (s.st == 1) ? s.op : 6'($urandom);
        @(negedge clk);
        n_checks++;
        if (state !== 4'(s.st) || obs !== exp_ctrl(s.st, s.op, s.rdy) ||
            {illegalOp, memTimeout} !== {s.ill, s.tmo}) begin
          n_fail++;
          $display("FAIL random_i%0d_op%h: got st=%0d ctrl=%h flags=%b want st=%0d ctrl=%h flags=%b",
                   k, s.op, state, obs, {illegalOp, memTimeout}, s.st,
                   exp_ctrl(s.st, s.op, s.rdy), {s.ill, s.tmo});
        end
        tick();
      end
      if (trapped) do_reset();
    end
  endtask

  initial begin
    reset    = 1'b1;
    memReady = 1'b0;
    opcode   = 6'h00;
    test_reset();
    test_rtype();
    test_load_stall();
    test_store();
    test_illegal();
    test_timeout();
    test_jump();
    test_midflight_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
